// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo slice: baud divisors for a 12 MHz
// clock and the state encoding used by both the receive and transmit FSMs.
package uart_pkg;

  localparam int B115200 = 104;
  localparam int B57600  = 208;
  localparam int B38400  = 313;
  localparam int B19200  = 625;
  localparam int B9600   = 1250;
  localparam int B4800   = 2500;
  localparam int B2400   = 5000;
  localparam int B1200   = 10000;
  localparam int B600    = 20000;
  localparam int B300    = 40000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: synchronizes the raw serial line, samples each bit at its
// middle and pulses rx_valid for one cycle when a frame has a good stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUDRATE = B115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rx_valid
);

  localparam int CW = $clog2(BAUDRATE) + 1;
  localparam logic [CW-1:0] FULL = CW'(BAUDRATE - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUDRATE / 2 - 1);

  logic            rx_meta;
  logic            rxs;
  uart_state_t     state;
  logic [CW-1:0]   cnt;
  logic [3:0]      bit_idx;
  logic [7:0]      shreg;
  logic            frame_err;

  // The line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt       <= '0;
          bit_idx   <= '0;
          frame_err <= 1'b0;
          if (!rxs) state <= START;
        end
        START: begin
          if (cnt == HALF) begin
            cnt   <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == 4'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // After a framing error, hold here until the line is back to idle.
          if (frame_err) begin
            if (rxs) state <= IDLE;
          end else if (cnt == FULL) begin
            cnt <= '0;
            if (rxs) begin
              data     <= shreg;
              rx_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: on start (while idle) sends start bit, data LSB first and
// a stop bit, each held for exactly BAUDRATE clock cycles.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUDRATE = B115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int CW = $clog2(BAUDRATE) + 1;
  localparam logic [CW-1:0] FULL = CW'(BAUDRATE - 1);

  uart_state_t   state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    shreg;

  assign busy = (state != IDLE);

  // The next bit is placed on tx at the edge that ends the current bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          tx      <= 1'b1;
          if (start) begin
            shreg <= data;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
            state <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL) begin
            cnt <= '0;
            if (bit_idx == 4'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo.sv
// Serial loopback top: every correctly received byte is queued in a single
// pending slot and retransmitted; its low nibble is shown on the LEDs.
module uart_echo
  import uart_pkg::*;
#(
  parameter int BAUDRATE = B115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  output logic [3:0] leds
);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] pend;
  logic       pend_full;
  logic       tx_busy;
  logic       tx_start;

  assign tx_start = pend_full && !tx_busy;

  // A fresh byte always wins the slot; a load in the same cycle takes the old byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= '0;
      pend_full <= 1'b0;
      leds      <= '0;
    end else if (rx_valid) begin
      pend      <= rx_data;
      pend_full <= 1'b1;
      leds      <= rx_data[3:0];
    end else if (tx_start) begin
      pend_full <= 1'b0;
    end
  end

  uart_rx #(.BAUDRATE(BAUDRATE)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (rx_data),
    .rx_valid (rx_valid)
  );

  uart_tx #(.BAUDRATE(BAUDRATE)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .start (tx_start),
    .data  (pend),
    .tx    (tx),
    .busy  (tx_busy)
  );

endmodule

// File: tb/tb_uart_echo.sv
// Directed bench for uart_echo: drives 8N1 frames on rx and checks the echo
// on tx bit by bit, the LED nibble, glitch/framing rejection and reset.
module tb_uart_echo;

  localparam int BAUD  = 104;
  localparam int FRAME = 10 * BAUD;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       tx;
  logic [3:0] leds;

  int n_checks = 0;
  int n_pass   = 0;

  uart_echo #(.BAUDRATE(BAUD)) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .tx   (tx),
    .leds (leds)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("[TB] FAIL global_timeout: observed running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at a negedge; returns at a negedge so frames chain without a gap.
  task automatic applyStimulus(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BAUD) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BAUD) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_tx_fall(output logic ok, input int budget);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Entered one cycle into the start bit; checks first and last cycle of every bit.
  task automatic check_frame(input logic [7:0] d, input string tag);
    int   pos;
    logic expv;
    pos = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      expv = 1'b0;
      else if (k == 9) expv = 1'b1;
      else             expv = d[k-1];
      step_n(k * BAUD - pos);
      checkOutput($sformatf("%s_bit%0d_first", tag, k), tx, expv);
      step_n(BAUD - 1);
      checkOutput($sformatf("%s_bit%0d_last", tag, k), tx, expv);
      pos = k * BAUD + BAUD - 1;
    end
  endtask

  task automatic echo(input logic [7:0] d, input string tag);
    logic ok;
    wait_tx_fall(ok, 3 * FRAME);
    checkOutput({tag, "_txstart"}, ok, 1'b1);
    if (ok) check_frame(d, tag);
  endtask

  task automatic expect_echo_latency(input logic [7:0] d, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clk);
      #1;
      if (dut.u_rx.rx_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_rxvalid"}, ok, 1'b1);
    if (!ok) return;
    checkOutput({tag, "_rxdata"}, dut.u_rx.data, d);
    step_n(1);
    checkOutput({tag, "_pulse"}, dut.u_rx.rx_valid, 1'b0);
    checkOutput({tag, "_leds"}, leds, d[3:0]);
    checkOutput({tag, "_tx_pre"}, tx, 1'b1);
    step_n(1);
    checkOutput({tag, "_tx_fall"}, tx, 1'b0);
    check_frame(d, tag);
  endtask

  initial begin
    logic ok;
    logic tx_low;
    logic rv_seen;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_leds", leds, 4'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] idle line");
    tx_low = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step_n(1);
      if (tx !== 1'b1) tx_low = 1'b1;
    end
    checkOutput("idle_tx_low", tx_low, 1'b0);
    checkOutput("idle_leds", leds, 4'h0);

    $display("[TB] byte 0x55");
    @(negedge clk);
    fork
      applyStimulus(8'h55, 1'b1);
      expect_echo_latency(8'h55, "b55");
    join

    $display("[TB] byte 0x4B");
    repeat (416) @(negedge clk);
    fork
      applyStimulus(8'h4B, 1'b1);
      expect_echo_latency(8'h4B, "b4b");
    join

    $display("[TB] glitch");
    @(negedge clk);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    tx_low  = 1'b0;
    rv_seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step_n(1);
      if (tx !== 1'b1) tx_low = 1'b1;
      if (dut.u_rx.rx_valid === 1'b1) rv_seen = 1'b1;
    end
    checkOutput("glitch_rxvalid", rv_seen, 1'b0);
    checkOutput("glitch_tx_low", tx_low, 1'b0);

    $display("[TB] framing error then 0x3C");
    tx_low  = 1'b0;
    rv_seen = 1'b0;
    @(negedge clk);
    fork
      applyStimulus(8'hA5, 1'b0);
      for (int i = 0; i < FRAME + 300; i++) begin
        step_n(1);
        if (tx !== 1'b1) tx_low = 1'b1;
        if (dut.u_rx.rx_valid === 1'b1) rv_seen = 1'b1;
      end
    join
    checkOutput("ferr_rxvalid", rv_seen, 1'b0);
    checkOutput("ferr_tx_low", tx_low, 1'b0);
    checkOutput("ferr_leds", leds, 4'hB);
    repeat (50) @(negedge clk);
    fork
      applyStimulus(8'h3C, 1'b1);
      expect_echo_latency(8'h3C, "b3c");
    join

    $display("[TB] back-to-back 0x00 0xFF 0x81");
    @(negedge clk);
    fork
      begin
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h81, 1'b1);
      end
      begin
        echo(8'h00, "b2b_00");
        echo(8'hFF, "b2b_ff");
        echo(8'h81, "b2b_81");
      end
    join
    checkOutput("b2b_leds", leds, 4'h1);

    $display("[TB] reset mid-frame");
    @(negedge clk);
    fork
      begin
        applyStimulus(8'h96, 1'b1);
        applyStimulus(8'hF0, 1'b1);
      end
      begin
        wait_tx_fall(ok, 3 * FRAME);
        checkOutput("rst_txstart", ok, 1'b1);
        step_n(50);
        checkOutput("rst_pre_tx", tx, 1'b0);
        checkOutput("rst_pre_leds", leds, 4'h6);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_tx", tx, 1'b1);
        checkOutput("rst_leds", leds, 4'h0);
      end
    join
    @(negedge clk);
    rst = 1'b0;
    tx_low  = 1'b0;
    rv_seen = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      step_n(1);
      if (tx !== 1'b1) tx_low = 1'b1;
      if (dut.u_rx.rx_valid === 1'b1) rv_seen = 1'b1;
    end
    checkOutput("post_rst_rxvalid", rv_seen, 1'b0);
    checkOutput("post_rst_tx_low", tx_low, 1'b0);
    checkOutput("post_rst_leds", leds, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
